// File: rtl/enrg_coinc_trg_pkg.sv
// rtl/enrg_coinc_trg_pkg.sv - shared state encodings and counter width for the coincidence trigger
// No ports; imported by enrg_coinc_trg and sat_cnt16.
package enrg_coinc_trg_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_DLY   = 5'b00010,
    ST_REQ   = 5'b00100,
    ST_DEAD  = 5'b01000,
    ST_REARM = 5'b10000
  } state_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/enrg_coinc_trg_if.sv
// rtl/enrg_coinc_trg_if.sv - trigger inputs and request/acknowledge handshake bundle
// Signals: trg_a, trg_b (detector triggers), ack (downstream acknowledge),
//          trg_req (coincidence request), busy (state machine not idle).
// master: trigger source / downstream side; slave: enrg_coinc_trg.
interface enrg_coinc_trg_if;
  logic trg_a;
  logic trg_b;
  logic ack;
  logic trg_req;
  logic busy;

  modport master (output trg_a, output trg_b, output ack, input trg_req, input busy);
  modport slave  (input trg_a, input trg_b, input ack, output trg_req, output busy);
endinterface

// File: rtl/enrg_coinc_trg_sat_cnt16.sv
// rtl/enrg_coinc_trg_sat_cnt16.sv - 16-bit saturating event counter
// Ports: clk, rst (async active-high), inc (count enable), cnt (current count, sticks at all-ones).
module sat_cnt16
  import enrg_coinc_trg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/enrg_coinc_trg.sv
// rtl/enrg_coinc_trg.sv - two-channel energy-detector coincidence trigger with delay and dead time
// Ports: clk, rst (async active-high); mask[1:0] channel enables (bit0=A, bit1=B);
//        mode (0=AND, 1=OR of enabled channels); delay[3:0] request delay; dead_time[7:0];
//        trig (slave modport: trg_a, trg_b, ack in; trg_req, busy out);
//        acc_cnt, lost_cnt (accepted / lost counters, only when COINC_CNT_EN is defined).
// Macro: COINC_CNT_EN enables the accepted/lost counters and their ports.
module enrg_coinc_trg
  import enrg_coinc_trg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mask,
  input  logic             mode,
  input  logic [3:0]       delay,
  input  logic [7:0]       dead_time,
  enrg_coinc_trg_if.slave  trig
`ifdef COINC_CNT_EN
  ,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] lost_cnt
`endif
);

  logic       coinc;
  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  // In AND mode a disabled channel counts as "present" so it cannot block;
  // an empty mask would then read as always-coincident, so it is forced off.
  always_comb begin
    coinc = 1'b0;
    if (mask != 2'b00) begin
      if (mode)
        coinc = (trig.trg_a & mask[0]) | (trig.trg_b & mask[1]);
      else
        coinc = (trig.trg_a | ~mask[0]) & (trig.trg_b | ~mask[1]);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (coinc) begin
          state_nxt = ST_DLY;
          cnt_nxt   = 8'd0;
        end
      end
      ST_DLY: begin
        if (cnt == {4'd0, delay})
          state_nxt = ST_REQ;
        else
          cnt_nxt = cnt + 8'd1;
      end
      ST_REQ: begin
        if (trig.ack) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = 8'd0;
        end
      end
      ST_DEAD: begin
        if (cnt == dead_time)
          state_nxt = ST_REARM;
        else
          cnt_nxt = cnt + 8'd1;
      end
      ST_REARM: begin
        // Wait for the stretched input to drop so one pulse fires only once.
        if (!coinc)
          state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // trg_req and busy are decoded from the next state so they change on the
  // same edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= 8'd0;
      trig.trg_req <= 1'b0;
      trig.busy    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      trig.trg_req <= (state_nxt == ST_REQ);
      trig.busy    <= (state_nxt != ST_IDLE);
    end
  end

`ifdef COINC_CNT_EN
  logic coinc_q;
  logic acc_inc;
  logic lost_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      coinc_q <= 1'b0;
    else
      coinc_q <= coinc;
  end

  assign acc_inc  = (state == ST_REQ) && trig.ack;
  assign lost_inc = coinc && !coinc_q && (state != ST_IDLE);

  sat_cnt16 u_acc_cnt (
    .clk (clk),
    .rst (rst),
    .inc (acc_inc),
    .cnt (acc_cnt)
  );

  sat_cnt16 u_lost_cnt (
    .clk (clk),
    .rst (rst),
    .inc (lost_inc),
    .cnt (lost_cnt)
  );
`endif

endmodule

// File: doc/enrg_coinc_trg.md
ENRG_COINC_TRG -- requirements
Module: enrg_coinc_trg

Interface
REQ-001 Clock  input  1  100 MHz system clock; all state updates on its rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 TrgA  input  1  stretched synchronous energy-detector trigger, channel A.
REQ-004 TrgB  input  1  stretched synchronous energy-detector trigger, channel B.
REQ-005 Mask  input  2  channel enables; bit0 = A, bit1 = B.
REQ-006 Mode  input  1  0 = AND of enabled channels, 1 = OR of enabled channels.
REQ-007 Delay  input  4  trigger request delay, in clock cycles.
REQ-008 DeadTime  input  8  dead time after acknowledge, in clock cycles.
REQ-009 Ack  input  1  downstream acknowledge of TrgReq.
REQ-010 TrgReq  output  1  coincidence trigger request, held high until acknowledged.
REQ-011 Busy  output  1  high whenever the state machine is not in Idle.
REQ-012 AccCnt  output  16  accepted-trigger count; present only with COINC_CNT_EN.
REQ-013 LostCnt  output  16  lost-coincidence count; present only with COINC_CNT_EN.

Function
REQ-014 Combinational Coinc SHALL be computed as follows:
- Mode=1: (TrgA&Mask[0]) | (TrgB&Mask[1]).
- Mode=0: (TrgA|~Mask[0]) & (TrgB|~Mask[1]).
- Mask=00 forces Coinc=0 in both modes.
REQ-015 The state machine SHALL have one-hot states Idle, Dly, Req, Dead and Rearm.
REQ-016 Idle: Coinc=1 -> Dly with Cnt<=0; otherwise stay in Idle.
REQ-017 Dly: Cnt==Delay -> Req; otherwise Cnt<=Cnt+1.
REQ-018 Req: TrgReq=1; Ack=1 -> Dead with Cnt<=0; otherwise hold.
REQ-019 Dead: Cnt==DeadTime -> Rearm; otherwise Cnt<=Cnt+1 (Cnt is 8 bits wide).
REQ-020 Rearm: Coinc=0 -> Idle; otherwise hold, so one stretched pulse never retriggers.
REQ-021 TrgReq SHALL be a registered output, high exactly while the state is Req.
REQ-022 Latency SHALL be: TrgReq rises Delay+2 rising edges after the first edge that samples Coinc=1 in Idle.
REQ-023 Ack SHALL be ignored in every state except Req.
REQ-024 Ack already high on Req entry SHALL give a TrgReq pulse exactly one cycle wide.
REQ-025 Dead SHALL last DeadTime+1 cycles; DeadTime=0 gives one cycle.
REQ-026 Delay and DeadTime SHALL be sampled live on every comparison; a change mid-count takes effect immediately.
REQ-027 Busy SHALL be registered, with the same timing as the state register.

Reset
REQ-028 Reset=1 SHALL asynchronously force:
- state Idle, Cnt=0;
- TrgReq=0, Busy=0;
- AccCnt=0 and LostCnt=0 (when present).
REQ-029 Reset asserted mid-operation SHALL abandon any pending request with no acknowledge needed.
REQ-030 After reset release, the first rising edge SHALL evaluate Idle normally.

Configuration
REQ-031 The macro COINC_CNT_EN SHALL control the counters:
- Defined: AccCnt increments on each Req->Dead transition.
- Defined: LostCnt increments on each rising edge of Coinc (registered Coinc 0->1) seen in any state except Idle.
- Defined: both counters are 16-bit and saturate at 0xFFFF.
- Undefined: both ports and all counter logic are absent; all other behaviour is identical.

Structure
REQ-032 The shared package SHALL hold:
- the state encodings Idle=5'b00001, Dly=5'b00010, Req=5'b00100, Dead=5'b01000, Rearm=5'b10000;
- the counter width constant (16).
REQ-033 One sub-module, sat_cnt16, SHALL implement the saturating counter and be instantiated twice under COINC_CNT_EN.

Verification
REQ-034 Mask=11, Mode=0, Delay=3, DeadTime=5, TrgA and TrgB high for 8 cycles together, Ack one cycle after TrgReq:
- TrgReq rises 5 edges after the first coincident sample;
- Busy stays high through Rearm until both inputs fall;
- AccCnt=1.
REQ-035 Mask=01, Mode=0, TrgB never asserted, TrgA pulsed -> trigger accepted (B ignored).
REQ-036 Mask=00 with both inputs pulsed -> TrgReq never asserts.
REQ-037 Mode=1, Mask=11, Delay=0, Ack tied high:
- TrgA pulse -> TrgReq high for exactly 1 cycle, 2 edges after the sample;
- a second TrgB pulse during Dead -> LostCnt=1 and no second TrgReq.
REQ-038 Hold Ack low for 20 cycles in Req -> TrgReq remains high all 20 cycles; assert Reset -> TrgReq=0 and Busy=0 immediately, without waiting for a clock edge.
REQ-039 Build without COINC_CNT_EN, rerun REQ-034 -> identical TrgReq and Busy waveforms.
